mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter: response-owner encoding,
// datapath widths and the default starvation limit.
package mem_arbiter_pkg;

  localparam int AW             = 24;
  localparam int DW             = 24;
  localparam int STARVE_MAX_DEF = 4;

  // Which requester owns the read data returning in the cycle after issue.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } owner_e;

  // Everything about an issued access that the response cycle needs to know.
  typedef struct packed {
    owner_e owner;
    logic   store;     // MA access was a store: ack only, no read data
    logic   if_flush;  // IF fetch was flushed in its own issue cycle
  } resp_tag_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) in front of a
// single-port memory with one-cycle read latency. MA has priority, but IF is
// guaranteed a slot once MA has won STARVE_MAX times in a row against it.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_in,
  input  logic [AW-1:0] if_addr_in,
  output logic          if_gnt_out,
  output logic          if_valid_out,
  output logic [DW-1:0] if_rdata_out,
  input  logic          ma_req_in,
  input  logic          ma_we_in,
  input  logic [AW-1:0] ma_addr_in,
  input  logic [DW-1:0] ma_wdata_in,
  output logic          ma_gnt_out,
  output logic          ma_valid_out,
  output logic [DW-1:0] ma_rdata_out,
  input  logic          flush_in,
  output logic          mem_en_out,
  output logic          mem_we_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  resp_tag_t     tag_q, tag_d;
  logic          if_win, if_gnt, ma_gnt;

  // Arbitration: IF only beats a concurrent MA request once starvation saturates.
  // Grants are forced low while reset is held.
  always_comb begin
    if_win = if_req_in && (!ma_req_in || (starve_q == SMAX));
    if_gnt = !rst && if_win;
    ma_gnt = !rst && ma_req_in && !if_win;
  end

  // Starvation counter: counts MA wins over a waiting IF, cleared once IF is
  // served or stops asking.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_in || if_gnt)
      starve_d = '0;
    else if (ma_gnt && (starve_q != SMAX))
      starve_d = starve_q + CW'(1);
  end

  // Response tag for the access issued this cycle.
  always_comb begin
    tag_d          = '0;
    tag_d.owner    = if_gnt ? OWN_IF : (ma_gnt ? OWN_MA : OWN_NONE);
    tag_d.store    = ma_gnt && ma_we_in;
    tag_d.if_flush = if_gnt && flush_in;
  end

  // Arbitration state; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      tag_q    <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  // Memory command and grants, driven from the selected requester.
  always_comb begin
    if_gnt_out    = if_gnt;
    ma_gnt_out    = ma_gnt;
    mem_en_out    = if_gnt || ma_gnt;
    mem_we_out    = ma_gnt && ma_we_in;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    if (if_gnt) begin
      mem_addr_out  = if_addr_in;
    end else if (ma_gnt) begin
      mem_addr_out  = ma_addr_in;
      mem_wdata_out = ma_wdata_in;
    end
  end

  // Response steering: only the owner sees read data; a flush in either the
  // issue or the response cycle hides the fetch result.
  always_comb begin
    if_valid_out = 1'b0;
    if_rdata_out = '0;
    ma_valid_out = 1'b0;
    ma_rdata_out = '0;
    if (!rst) begin
      if (tag_q.owner == OWN_IF) begin
        if_valid_out = !tag_q.if_flush && !flush_in;
        if_rdata_out = mem_rdata_in;
      end
      if (tag_q.owner == OWN_MA) begin
        ma_valid_out = 1'b1;
        ma_rdata_out = tag_q.store ? '0 : mem_rdata_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a small memory model and a queue of
// expected responses, plus a hand sequence for asynchronous reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [1:0] G_NONE = 2'd0, G_IF = 2'd1, G_MA = 2'd2;

  typedef struct {
    string       name;
    logic        rst;
    logic        if_req;
    logic [23:0] if_addr;
    logic        ma_req;
    logic        ma_we;
    logic [23:0] ma_addr;
    logic [23:0] ma_wdata;
    logic        flush;
    logic [1:0]  gnt;
  } vec_t;

  typedef struct {
    logic [1:0]  own;
    logic        we;
    logic        fl;
    logic [23:0] data;
  } exp_t;

  logic        clk, rst;
  logic        if_req_in, if_gnt_out, if_valid_out;
  logic [23:0] if_addr_in, if_rdata_out;
  logic        ma_req_in, ma_we_in, ma_gnt_out, ma_valid_out;
  logic [23:0] ma_addr_in, ma_wdata_in, ma_rdata_out;
  logic        flush_in, mem_en_out, mem_we_out;
  logic [23:0] mem_addr_out, mem_wdata_out, mem_rdata_in;

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs[$];
  exp_t sb[$];

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
    .if_valid_out(if_valid_out), .if_rdata_out(if_rdata_out),
    .ma_req_in(ma_req_in), .ma_we_in(ma_we_in), .ma_addr_in(ma_addr_in),
    .ma_wdata_in(ma_wdata_in), .ma_gnt_out(ma_gnt_out),
    .ma_valid_out(ma_valid_out), .ma_rdata_out(ma_rdata_out),
    .flush_in(flush_in),
    .mem_en_out(mem_en_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 1K words, unwritten words read a fixed pattern.
  logic [23:0] mem_q [1024];
  bit          wr_v  [1024];

  function automatic logic [23:0] dflt(input logic [23:0] a);
    if (a == 24'h000010) return 24'hABCDEF;
    return a ^ 24'h5A5A5A;
  endfunction

  function automatic logic [23:0] exp_rd(input logic [23:0] a);
    if (wr_v[a[9:0]]) return mem_q[a[9:0]];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en_out && mem_we_out) begin
      mem_q[mem_addr_out[9:0]] <= mem_wdata_out;
      wr_v[mem_addr_out[9:0]]  <= 1'b1;
      mem_rdata_in             <= 24'hC0FFEE;
    end else if (mem_en_out) begin
      mem_rdata_in <= exp_rd(mem_addr_out);
    end else begin
      mem_rdata_in <= 24'hBAD0BA;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [79:0] act,
                     input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
  endtask

  task automatic add(input string nm, input logic r, input logic ir,
                     input logic [23:0] ia, input logic mr, input logic mw,
                     input logic [23:0] ma, input logic [23:0] md,
                     input logic fl, input logic [1:0] g);
    vec_t v;
    v.name = nm; v.rst = r; v.if_req = ir; v.if_addr = ia; v.ma_req = mr;
    v.ma_we = mw; v.ma_addr = ma; v.ma_wdata = md; v.flush = fl; v.gnt = g;
    vecs.push_back(v);
  endtask

  task automatic both(input string nm, input logic [1:0] g);
    add(nm, 0, 1, 24'h000020, 1, 0, 24'h000030, 24'h0, 0, g);
  endtask

  task automatic idle(input string nm, input logic fl);
    add(nm, 0, 0, 24'h0, 0, 0, 24'h0, 24'h0, fl, G_NONE);
  endtask

  // Apply one vector and check the issue-cycle command plus whatever
  // response the previous cycle produced.
  task automatic apply(input int i, input vec_t v);
    exp_t        e, n;
    logic        e_en, e_we, e_ifv, e_mav;
    logic [23:0] e_addr, e_wd, e_ifd, e_mad;
    @(posedge clk);
    #1;
    rst = v.rst; if_req_in = v.if_req; if_addr_in = v.if_addr;
    ma_req_in = v.ma_req; ma_we_in = v.ma_we; ma_addr_in = v.ma_addr;
    ma_wdata_in = v.ma_wdata; flush_in = v.flush;
    @(negedge clk);
    e = '{own: G_NONE, we: 1'b0, fl: 1'b0, data: 24'h0};
    if (sb.size() > 0) e = sb.pop_front();
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    e_ifv = 0; e_ifd = '0; e_mav = 0; e_mad = '0;
    if (!v.rst) begin
      e_en   = (v.gnt != G_NONE);
      e_we   = (v.gnt == G_MA) && v.ma_we;
      e_addr = (v.gnt == G_IF) ? v.if_addr : (v.gnt == G_MA) ? v.ma_addr : 24'h0;
      e_wd   = (v.gnt == G_MA) ? v.ma_wdata : 24'h0;
      e_ifv  = (e.own == G_IF) && !e.fl && !v.flush;
      e_ifd  = (e.own == G_IF) ? e.data : 24'h0;
      e_mav  = (e.own == G_MA);
      e_mad  = (e.own == G_MA && !e.we) ? e.data : 24'h0;
    end
    chk({v.name, ".gnt"}, i, {78'h0, if_gnt_out, ma_gnt_out},
        {78'h0, (!v.rst && v.gnt == G_IF), (!v.rst && v.gnt == G_MA)});
    chk({v.name, ".cmd"}, i, {30'h0, mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out},
        {30'h0, e_en, e_we, e_addr, e_wd});
    chk({v.name, ".if_rsp"}, i, {55'h0, if_valid_out, if_rdata_out}, {55'h0, e_ifv, e_ifd});
    chk({v.name, ".ma_rsp"}, i, {55'h0, ma_valid_out, ma_rdata_out}, {55'h0, e_mav, e_mad});
    n = '{own: G_NONE, we: 1'b0, fl: 1'b0, data: 24'h0};
    if (v.rst) begin
      sb.delete();
    end else begin
      n.own  = v.gnt;
      n.we   = (v.gnt == G_MA) && v.ma_we;
      n.fl   = (v.gnt == G_IF) && v.flush;
      n.data = (v.gnt == G_IF) ? exp_rd(v.if_addr) :
               (v.gnt == G_MA) ? exp_rd(v.ma_addr) : 24'h0;
    end
    sb.push_back(n);
  endtask

  initial begin
    rst = 1; if_req_in = 0; if_addr_in = 0; ma_req_in = 0; ma_we_in = 0;
    ma_addr_in = 0; ma_wdata_in = 0; flush_in = 0;

    // reset state
    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, G_NONE);
    add("rst", 1, 1, 24'h10, 1, 0, 24'h30, 0, 0, G_NONE);
    // IF only: 0x000010 reads 0xABCDEF
    add("if_only", 0, 1, 24'h000010, 0, 0, 0, 0, 0, G_IF);
    idle("if_rsp", 0);
    // starvation: MA x4, IF, MA x3
    for (int k = 0; k < 8; k++) both("starve", (k == 4) ? G_IF : G_MA);
    idle("idle", 0);
    // IF dropping its request clears the count
    both("clr", G_MA); both("clr", G_MA);
    add("clr_ma", 0, 0, 0, 1, 0, 24'h030, 0, 0, G_MA);
    for (int k = 0; k < 4; k++) both("clr", G_MA);
    both("clr_if", G_IF);
    idle("idle", 0);
    // store then load back
    add("store", 0, 0, 0, 1, 1, 24'h000100, 24'h123456, 0, G_MA);
    add("ld_back", 0, 0, 0, 1, 0, 24'h000100, 24'h0, 0, G_MA);
    idle("ld_rsp", 0);
    // flush in response cycle, then a clean fetch
    add("fl_if", 0, 1, 24'h20, 0, 0, 0, 0, 0, G_IF);
    idle("fl_n1", 1);
    add("if_ok", 0, 1, 24'h30, 0, 0, 0, 0, 0, G_IF);
    idle("if_ok_rsp", 0);
    // flush in issue cycle does not block the grant
    add("fl_n", 0, 1, 24'h40, 0, 0, 0, 0, 1, G_IF);
    idle("fl_n_rsp", 0);
    // flush has no effect on MA
    add("fl_ma", 0, 0, 0, 1, 0, 24'h50, 0, 1, G_MA);
    idle("fl_ma_rsp", 1);
    // back-to-back fetches with a flush in the middle
    add("b2b", 0, 1, 24'h60, 0, 0, 0, 0, 0, G_IF);
    add("b2b_fl", 0, 1, 24'h70, 0, 0, 0, 0, 1, G_IF);
    add("b2b", 0, 1, 24'h80, 0, 0, 0, 0, 0, G_IF);
    idle("b2b_rsp", 0);
    // reset kills an in-flight load
    add("ld", 0, 0, 0, 1, 0, 24'h90, 0, 0, G_MA);
    add("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, G_NONE);
    idle("post_rst", 0);
    add("ld2", 0, 0, 0, 1, 0, 24'h90, 0, 0, G_MA);
    idle("ld2_rsp", 0);
    // reset clears a partly built starvation count
    for (int k = 0; k < 3; k++) both("pre", G_MA);
    add("rst_st", 1, 1, 24'h20, 1, 0, 24'h30, 0, 0, G_NONE);
    for (int k = 0; k < 4; k++) both("post", G_MA);
    both("post_if", G_IF);
    idle("idle", 0);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Hand sequence: reset asserted between edges acts immediately.
    @(posedge clk); #1;
    ma_req_in = 1; ma_we_in = 0; ma_addr_in = 24'hA0;
    @(posedge clk); #2;
    chk("async.rsp_before", 0, {79'h0, ma_valid_out}, 80'h1);
    rst = 1; #1;
    chk("async.cmd", 0, {78'h0, ma_gnt_out, mem_en_out}, 80'h0);
    chk("async.rsp", 0, {55'h0, ma_valid_out, ma_rdata_out}, 80'h0);
    @(negedge clk);
    ma_req_in = 0; rst = 0;
    @(posedge clk); #1;
    chk("async.after", 0, {78'h0, ma_valid_out, if_valid_out}, 80'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
